// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, FSM states, ALU op codes
// and instruction field positions.
package control_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_MOV  = 3'b010,
        OP_ADD  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_SHF  = 3'b110,
        OP_SKIP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2
    } state_e;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_AND = 2'b01;
    localparam logic [1:0] ALU_OP_OR  = 2'b10;
    localparam logic [1:0] ALU_OP_SHF = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int DST_BIT = 4;
    localparam int SRC_BIT = 3;
    localparam int MOD_BIT = 2;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    function automatic logic is_alu_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_OR) || (op == OP_SHF);
    endfunction

    function automatic logic [1:0] alu_op_of(input opcode_e op);
        logic [1:0] code;
        case (op)
            OP_AND:  code = ALU_OP_AND;
            OP_OR:   code = ALU_OP_OR;
            OP_SHF:  code = ALU_OP_SHF;
            default: code = ALU_OP_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational control-word decoder: maps registered state, IR and skip flag
// onto the datapath controls. Everything not explicitly driven stays 0.
module control_decode
    import control_unit_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic [7:0] ir_i,
    input  logic       skip_i,
    output logic       alu_oe_o,
    output logic       alu_sub_o,
    output logic       alu_shl_o,
    output logic [1:0] alu_op_o,
    output logic       reg_wr0_o,
    output logic       reg_wr1_o,
    output logic       reg_bus_sel_o,
    output logic       reg_bus_en_o,
    output logic       alu_sel_o,
    output logic [7:0] bus_ovr_o,
    output logic       bus_ovr_en_o
);

    opcode_e op;
    logic    dst;
    logic    src;
    logic    mod_bit;

    assign op      = opcode_e'(ir_i[OPC_MSB:OPC_LSB]);
    assign dst     = ir_i[DST_BIT];
    assign src     = ir_i[SRC_BIT];
    assign mod_bit = ir_i[MOD_BIT];

    always_comb begin
        alu_oe_o      = 1'b0;
        alu_sub_o     = 1'b0;
        alu_shl_o     = 1'b0;
        alu_op_o      = 2'b00;
        reg_wr0_o     = 1'b0;
        reg_wr1_o     = 1'b0;
        reg_bus_sel_o = 1'b0;
        reg_bus_en_o  = 1'b0;
        alu_sel_o     = 1'b0;
        bus_ovr_o     = 8'h00;
        bus_ovr_en_o  = 1'b0;

        // A squashed instruction spends its EX1 with every control low.
        if (state_e'(state_i) == ST_EX1 && !skip_i) begin
            case (op)
                OP_LDI: begin
                    bus_ovr_o    = {4'b0000, ir_i[IMM_MSB:IMM_LSB]};
                    bus_ovr_en_o = 1'b1;
                    reg_wr0_o    = ~dst;
                    reg_wr1_o    = dst;
                end
                OP_MOV: begin
                    reg_bus_en_o  = 1'b1;
                    reg_bus_sel_o = src;
                    reg_wr0_o     = ~dst;
                    reg_wr1_o     = dst;
                end
                OP_ADD, OP_AND, OP_OR, OP_SHF: begin
                    reg_bus_en_o  = 1'b1;
                    reg_bus_sel_o = src;
                    alu_sel_o     = dst;
                    alu_op_o      = alu_op_of(op);
                    alu_sub_o     = (op == OP_ADD) && mod_bit;
                    alu_shl_o     = (op == OP_SHF) && mod_bit;
                end
                default: ;
            endcase
        end else if (state_e'(state_i) == ST_EX2 && is_alu_op(op)) begin
            alu_oe_o  = 1'b1;
            alu_sel_o = dst;
            alu_op_o  = alu_op_of(op);
            alu_sub_o = (op == OP_ADD) && mod_bit;
            alu_shl_o = (op == OP_SHF) && mod_bit;
            reg_wr0_o = ~dst;
            reg_wr1_o = dst;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for a two-register datapath: accepts one instruction
// byte at a time and steps it through EX1 (and EX2 for ALU ops).
//
// state   | meaning
// IDLE    | ready for an instruction; all controls low
// EX1     | first execute cycle (single-cycle ops finish here; ALU ops read operands)
// EX2     | ALU write-back; flag register captures N/Z on exit
module control_unit
    import control_unit_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_instr,
    input  logic       i_instrValid,
    output logic       o_instrReady,
    input  logic       i_aluFlagN,
    input  logic       i_aluFlagZ,
    output logic       o_ctrlAluOE,
    output logic       o_ctrlAluSub,
    output logic       o_ctrlAluShiftLeft,
    output logic [1:0] o_ctrlAluOp,
    output logic       o_ctrlRegWr0,
    output logic       o_ctrlRegWr1,
    output logic       o_ctrlRegBusSel,
    output logic       o_ctrlRegBusEn,
    output logic       o_ctrlAluSel,
    output logic [7:0] o_busOverride,
    output logic       o_busOverrideEn
);

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [1:0] flags_q, flags_d;   // {N, Z}
    logic       skip_q, skip_d;
    opcode_e    ir_op;
    logic       accept;

    assign ir_op = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);

    // Ready is qualified by reset so it reads 0 while reset is held.
    assign o_instrReady = (state_q == ST_IDLE) && i_reset;
    assign accept       = o_instrReady && i_instrValid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            ir_q    <= 8'h00;
            flags_q <= 2'b00;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ir_d    = i_instr;
                    state_d = ST_EX1;
                end
            end
            ST_EX1: begin
                if (skip_q) begin
                    skip_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (is_alu_op(ir_op)) begin
                    state_d = ST_EX2;
                end else begin
                    state_d = ST_IDLE;
                    if (ir_op == OP_SKIP)
                        skip_d = flags_q[ir_q[DST_BIT]];
                end
            end
            ST_EX2: begin
                flags_d = {i_aluFlagN, i_aluFlagZ};
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    control_decode u_decode (
        .state_i       (state_q),
        .ir_i          (ir_q),
        .skip_i        (skip_q),
        .alu_oe_o      (o_ctrlAluOE),
        .alu_sub_o     (o_ctrlAluSub),
        .alu_shl_o     (o_ctrlAluShiftLeft),
        .alu_op_o      (o_ctrlAluOp),
        .reg_wr0_o     (o_ctrlRegWr0),
        .reg_wr1_o     (o_ctrlRegWr1),
        .reg_bus_sel_o (o_ctrlRegBusSel),
        .reg_bus_en_o  (o_ctrlRegBusEn),
        .alu_sel_o     (o_ctrlAluSel),
        .bus_ovr_o     (o_busOverride),
        .bus_ovr_en_o  (o_busOverrideEn)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a random
// instruction stream checked against a per-instruction behavioural model.
module tb_control_unit;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_instr = 8'h00;
    logic       i_instrValid = 1'b0;
    logic       o_instrReady;
    logic       i_aluFlagN = 1'b0;
    logic       i_aluFlagZ = 1'b0;
    logic       o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft;
    logic [1:0] o_ctrlAluOp;
    logic       o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel;
    logic [7:0] o_busOverride;
    logic       o_busOverrideEn;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: flag register and pending skip
    bit m_n = 0, m_z = 0, m_skip = 0;

    typedef struct packed {
        logic       aluOE;
        logic       sub;
        logic       shl;
        logic [1:0] op;
        logic       wr0;
        logic       wr1;
        logic       busSel;
        logic       busEn;
        logic       aluSel;
        logic [7:0] ovr;
        logic       ovrEn;
    } cw_t;

    control_unit dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_instr            (i_instr),
        .i_instrValid       (i_instrValid),
        .o_instrReady       (o_instrReady),
        .i_aluFlagN         (i_aluFlagN),
        .i_aluFlagZ         (i_aluFlagZ),
        .o_ctrlAluOE        (o_ctrlAluOE),
        .o_ctrlAluSub       (o_ctrlAluSub),
        .o_ctrlAluShiftLeft (o_ctrlAluShiftLeft),
        .o_ctrlAluOp        (o_ctrlAluOp),
        .o_ctrlRegWr0       (o_ctrlRegWr0),
        .o_ctrlRegWr1       (o_ctrlRegWr1),
        .o_ctrlRegBusSel    (o_ctrlRegBusSel),
        .o_ctrlRegBusEn     (o_ctrlRegBusEn),
        .o_ctrlAluSel       (o_ctrlAluSel),
        .o_busOverride      (o_busOverride),
        .o_busOverrideEn    (o_busOverrideEn)
    );

    always #5 i_clk = ~i_clk;

    function automatic cw_t dut_cw();
        cw_t c;
        c.aluOE  = o_ctrlAluOE;
        c.sub    = o_ctrlAluSub;
        c.shl    = o_ctrlAluShiftLeft;
        c.op     = o_ctrlAluOp;
        c.wr0    = o_ctrlRegWr0;
        c.wr1    = o_ctrlRegWr1;
        c.busSel = o_ctrlRegBusSel;
        c.busEn  = o_ctrlRegBusEn;
        c.aluSel = o_ctrlAluSel;
        c.ovr    = o_busOverride;
        c.ovrEn  = o_busOverrideEn;
        return c;
    endfunction

    // Issue one instruction and check every cycle it occupies. fn/fz are the
    // ALU flags presented during EX2 (the only cycle they may be captured).
    task automatic exec(input logic [7:0] ins, input bit garbage, input bit fn, input bit fz);
        cw_t        e1, e2, got;
        int         n_cyc;
        bit         squash;
        logic [2:0] opc, rel;
        int         t;
        e1 = '0; e2 = '0; n_cyc = 1;
        squash = m_skip;
        opc = ins[7:5];
        if (!squash) begin
            if (opc == 3'd1) begin
                e1.ovr   = {4'h0, ins[3:0]};
                e1.ovrEn = 1'b1;
                e1.wr0   = ~ins[4];
                e1.wr1   = ins[4];
            end else if (opc == 3'd2) begin
                e1.busEn  = 1'b1;
                e1.busSel = ins[3];
                e1.wr0    = ~ins[4];
                e1.wr1    = ins[4];
            end else if (opc >= 3'd3 && opc <= 3'd6) begin
                n_cyc     = 2;
                rel       = opc - 3'd3;
                e1.busEn  = 1'b1;
                e1.busSel = ins[3];
                e1.aluSel = ins[4];
                e1.op     = rel[1:0];
                e1.sub    = (opc == 3'd3) && ins[2];
                e1.shl    = (opc == 3'd6) && ins[2];
                e2.aluSel = e1.aluSel;
                e2.op     = e1.op;
                e2.sub    = e1.sub;
                e2.shl    = e1.shl;
                e2.aluOE  = 1'b1;
                e2.wr0    = ~ins[4];
                e2.wr1    = ins[4];
            end
        end

        t = 0;
        while (!o_instrReady && t < 20) begin
            @(posedge i_clk); #1;
            t++;
        end
        n_checks++;
        if (!o_instrReady) begin
            n_fail++;
            $display("FAIL ready_timeout: ready=%b required 1", o_instrReady);
        end

        i_instr = ins;
        i_instrValid = 1'b1;
        @(posedge i_clk); #1;
        got = dut_cw();
        n_checks++;
        if (got !== e1) begin
            n_fail++;
            $display("FAIL ex1_controls ins=%h: got %h required %h", ins, got, e1);
        end
        n_checks++;
        if (o_instrReady !== 1'b0) begin
            n_fail++;
            $display("FAIL ex1_ready ins=%h: got %b required 0", ins, o_instrReady);
        end
        n_checks++;
        if ($countones({got.busEn, got.aluOE, got.ovrEn}) > 1 || (got.wr0 && got.wr1)) begin
            n_fail++;
            $display("FAIL ex1_exclusive ins=%h: got %h required at most one driver/writer", ins, got);
        end
        if (garbage) i_instr = 8'($urandom);
        else begin
            i_instrValid = 1'b0;
            i_instr = 8'($urandom);
        end
        i_aluFlagN = 1'($urandom);
        i_aluFlagZ = 1'($urandom);

        if (n_cyc == 2) begin
            @(posedge i_clk); #1;
            got = dut_cw();
            n_checks++;
            if (got !== e2) begin
                n_fail++;
                $display("FAIL ex2_controls ins=%h: got %h required %h", ins, got, e2);
            end
            n_checks++;
            if (o_instrReady !== 1'b0) begin
                n_fail++;
                $display("FAIL ex2_ready ins=%h: got %b required 0", ins, o_instrReady);
            end
            if (garbage) i_instr = 8'($urandom);
            i_aluFlagN = fn;
            i_aluFlagZ = fz;
        end

        @(posedge i_clk); #1;
        got = dut_cw();
        n_checks++;
        if (got !== '0 || o_instrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after ins=%h: controls %h ready %b required 0 / 1", ins, got, o_instrReady);
        end
        i_instrValid = 1'b0;
        i_aluFlagN = 1'($urandom);
        i_aluFlagZ = 1'($urandom);

        if (squash) m_skip = 0;
        else if (opc == 3'd7) m_skip = ins[4] ? m_n : m_z;
        if (n_cyc == 2) begin
            m_n = fn;
            m_z = fz;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_instrValid = 1'b1;
        i_instr = 8'h2A;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if (o_instrReady !== 1'b0 || dut_cw() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: ready %b controls %h required 0 / 0", o_instrReady, dut_cw());
        end
        i_instrValid = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        n_checks++;
        if (o_instrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", o_instrReady);
        end
        m_n = 0; m_z = 0; m_skip = 0;
    endtask

    task automatic test_ldi();
        exec(8'h2A, 0, 0, 0);
        exec(8'h3F, 0, 0, 0);
    endtask

    task automatic test_sub();
        exec(8'h74, 0, 0, 0);
        exec(8'hC4, 0, 1, 0);
        exec(8'h98, 0, 0, 1);
    endtask

    task automatic test_skip();
        exec(8'h60, 0, 0, 1);   // ADD ending Z=1
        exec(8'hE0, 0, 0, 0);   // SKIP Z -> taken
        exec(8'h25, 0, 0, 0);   // squashed LDI
        exec(8'h23, 0, 0, 0);   // executes
        exec(8'h60, 0, 0, 0);   // Z=0
        exec(8'hE0, 0, 0, 0);   // not taken
        exec(8'h31, 0, 0, 0);
        exec(8'h60, 0, 1, 1);   // Z=1, N=1
        exec(8'hE0, 0, 0, 0);
        exec(8'hF0, 0, 0, 0);   // squashed SKIP must not chain
        exec(8'h48, 0, 0, 0);   // MOV executes
        exec(8'hF0, 0, 0, 0);   // SKIP N, N=1 -> taken
        exec(8'h74, 0, 0, 0);   // squashed SUB, flags untouched
        exec(8'hF0, 0, 0, 0);   // still N=1 -> taken again
        exec(8'h50, 0, 0, 0);
    endtask

    task automatic test_ignore_while_busy();
        exec(8'h6C, 1, 0, 0);
        exec(8'h48, 1, 0, 0);
        exec(8'hD4, 1, 1, 1);
    endtask

    task automatic test_reset_mid_instr();
        i_instr = 8'h68;
        i_instrValid = 1'b1;
        @(posedge i_clk); #1;
        i_instrValid = 1'b0;
        @(posedge i_clk); #1;
        n_checks++;
        if (o_ctrlAluOE !== 1'b1 || o_ctrlRegWr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ex2: aluOE %b wr0 %b required 1 / 1", o_ctrlAluOE, o_ctrlRegWr0);
        end
        i_aluFlagZ = 1'b1;
        i_aluFlagN = 1'b1;
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if (dut_cw() !== '0 || o_instrReady !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_drop: controls %h ready %b required 0 / 0", dut_cw(), o_instrReady);
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (dut_cw() !== '0) begin
            n_fail++;
            $display("FAIL rst_no_write: controls %h required 0", dut_cw());
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        n_checks++;
        if (o_instrReady !== 1'b1 || dut_cw() !== '0) begin
            n_fail++;
            $display("FAIL rst_ready_after: ready %b controls %h required 1 / 0", o_instrReady, dut_cw());
        end
        m_n = 0; m_z = 0; m_skip = 0;
        exec(8'hE0, 0, 0, 0);   // flags were cleared: not taken
        exec(8'h2B, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            exec(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_sub();
        test_skip();
        test_ignore_while_busy();
        test_reset_mid_instr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
